// File: rtl/pwm_duty_ramp_pkg.sv
// Shared constants and types for the pwm duty path.
//   DC_W         : duty width, must match the pwm core's dc input.
//   MAX_DC       : largest legal duty; larger targets are clamped.
//   ramp_state_t : states of the duty-ramp controller.
package pwm_pkg;

    localparam int DC_W   = 7;
    localparam int MAX_DC = 100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } ramp_state_t;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Signal bundle between the pad-side control and the duty-ramp block.
//   enable    : master->slave, level, 1 = run toward target_dc, 0 = ramp to 0
//   kill      : master->slave, level, 1 = force duty to 0 immediately
//   target_dc : master->slave, requested duty (asynchronous to clk)
//   step      : master->slave, duty increment per tick, 0 acts as 1
//   dc        : slave->master, registered duty for the pwm core
//   ramping   : slave->master, 1 while in RAMP
//   at_target : slave->master, 1 when dc equals the effective target (not in KILL)
//   fault     : slave->master, 1 while in KILL
//   state     : slave->master, controller state for observation
// There is no valid/ready handshake: every input is a level sampled
// continuously through synchronisers, and every output is a level.
interface pwm_duty_ramp_if;
    import pwm_pkg::*;

    logic              enable;
    logic              kill;
    logic [DC_W-1:0]   target_dc;
    logic [3:0]        step;
    logic [DC_W-1:0]   dc;
    logic              ramping;
    logic              at_target;
    logic              fault;
    ramp_state_t       state;

    modport slave (
        input  enable, kill, target_dc, step,
        output dc, ramping, at_target, fault, state
    );

    modport master (
        output enable, kill, target_dc, step,
        input  dc, ramping, at_target, fault, state
    );

endinterface

// File: rtl/pwm_duty_ramp_sync2.sv
// Two-flop synchroniser, parameterised width, asynchronous active-high reset.
//   clk   : destination clock
//   reset : asynchronous, active-high; clears both stages
//   i_d   : asynchronous input
//   o_q   : synchronised output, two clk cycles after i_d
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= '0;
            r_q    <= '0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pwm_duty_ramp.sv
// Duty-ramp feeder for the pwm core. Slews the output duty toward a clamped
// target at most `step` per prescaler tick, and drops it to zero on kill.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : pwm_duty_ramp_if.slave (enable, kill, target_dc, step in;
//           dc, ramping, at_target, fault, state out)
// Parameter TICK_DIV: clk cycles per ramp step opportunity (>= 2).
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic             clk,
    input  logic             reset,
    pwm_duty_ramp_if.slave   bus
);

    localparam int              CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [DC_W-1:0] MAX_V    = DC_W'(MAX_DC);

    logic [1:0]      w_ctl_s;
    logic            w_en_s;
    logic            w_kill_s;
    logic [DC_W-1:0] w_tgt_s;
    logic [3:0]      w_step_s;

    sync2 #(.W(2)) u_sync_ctl (
        .clk   (clk),
        .reset (reset),
        .i_d   ({bus.kill, bus.enable}),
        .o_q   (w_ctl_s)
    );

    sync2 #(.W(DC_W)) u_sync_tgt (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.target_dc),
        .o_q   (w_tgt_s)
    );

    sync2 #(.W(4)) u_sync_step (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.step),
        .o_q   (w_step_s)
    );

    assign w_en_s   = w_ctl_s[0];
    assign w_kill_s = w_ctl_s[1];

    ramp_state_t     r_state;
    logic [DC_W-1:0] r_dc;
    logic [CW-1:0]   r_cnt;

    logic [DC_W-1:0] w_tgt;
    logic [DC_W-1:0] w_eff;
    logic [DC_W:0]   w_stp;
    logic [DC_W:0]   w_dc_x;
    logic [DC_W:0]   w_eff_x;
    logic [DC_W:0]   w_up;
    logic [DC_W-1:0] w_up_c;
    logic [DC_W-1:0] w_dn_c;
    logic [DC_W-1:0] w_next;
    logic            w_run;
    logic            w_tick;

    assign w_tgt   = (w_tgt_s > MAX_V) ? MAX_V : w_tgt_s;
    assign w_eff   = w_en_s ? w_tgt : '0;
    assign w_stp   = (w_step_s == 4'd0) ? (DC_W+1)'(1) : (DC_W+1)'(w_step_s);

    // One extra bit so dc+step and eff+step never wrap.
    assign w_dc_x  = {1'b0, r_dc};
    assign w_eff_x = {1'b0, w_eff};
    assign w_up    = w_dc_x + w_stp;
    assign w_up_c  = (w_up > w_eff_x) ? w_eff : w_up[DC_W-1:0];
    // Subtract only when the result stays at or above the target,
    // otherwise land exactly on the target (also covers underflow).
    assign w_dn_c  = (w_dc_x >= (w_eff_x + w_stp)) ? DC_W'(w_dc_x - w_stp) : w_eff;
    assign w_next  = (r_dc < w_eff) ? w_up_c :
                     (r_dc > w_eff) ? w_dn_c : r_dc;

    assign w_run   = (r_state == RAMP) || (r_state == HOLD);
    assign w_tick  = w_run && (r_cnt == CNT_LAST);

    // Prescaler free-runs across RAMP<->HOLD so retargeting from HOLD
    // keeps the existing tick phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!w_run) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_dc    <= '0;
        end else if (w_kill_s) begin
            r_state <= KILL;
            r_dc    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dc <= '0;
                    if (w_en_s) begin
                        r_state <= (w_tgt != '0) ? RAMP : HOLD;
                    end
                end
                RAMP: begin
                    if (w_tick) begin
                        r_dc <= w_next;
                        if (w_next == w_eff) begin
                            r_state <= w_en_s ? HOLD : IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (!w_en_s && (r_dc == '0)) begin
                        r_state <= IDLE;
                    end else if (w_eff != r_dc) begin
                        r_state <= RAMP;
                    end
                end
                KILL: begin
                    // No auto-restart: enable must drop before leaving.
                    if (!w_en_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_dc    <= '0;
                end
            endcase
        end
    end

    assign bus.dc        = r_dc;
    assign bus.state     = r_state;
    assign bus.ramping   = (r_state == RAMP);
    assign bus.fault     = (r_state == KILL);
    assign bus.at_target = (r_state != KILL) && (r_dc == w_eff);

endmodule
